// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Defaults for the top-level parameters and the hold-buffer state encoding.
package instruction_fetch_stage_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int          PC_INC   = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } hold_state_t;

endpackage

// File: rtl/if_id_hold_buffer.sv
// One-entry hold buffer that keeps the ID-stage instruction stable across stalls.
// state | meaning
// LIVE  | ID sees imem_rdata directly (hold_valid=0)
// HELD  | ID sees the word captured on the first stall cycle (hold_valid=1)
module if_id_hold_buffer
  import instruction_fetch_stage_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load_id,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instruction
);

  hold_state_t      state_q, state_d;
  logic             capture;
  logic [WIDTH-1:0] hold_instr;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= LIVE;
      hold_instr <= '0;
    end else begin
      state_q <= state_d;
      if (capture) hold_instr <= imem_rdata;
    end
  end

  // Capture only on the LIVE->HELD transition so a long stall keeps the first word.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      LIVE: begin
        if (!load_id) begin
          state_d = HELD;
          capture = 1'b1;
        end
      end
      HELD: begin
        if (load_id) state_d = LIVE;
      end
      default: state_d = LIVE;
    endcase
  end

  assign instruction = (state_q == HELD) ? hold_instr : imem_rdata;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// A taken branch redirects the PC and injects exactly one bubble into ID.
module instruction_fetch_stage #(
  parameter int                XLEN     = instruction_fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0]   PC_RESET = instruction_fetch_stage_pkg::PC_RESET,
  parameter int                PC_INC   = instruction_fetch_stage_pkg::PC_INC
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            pc_write,
  input  logic            enable__IF_ID,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PC__IF_ID,
  output logic [XLEN-1:0] instruction__IF_ID,
  output logic            valid__IF_ID
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            load_id;

  // The branch is older than any stalled instruction, so it beats pc_write=0.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken)  pc_d = branch_target;
    else if (pc_write) pc_d = pc_q + XLEN'(PC_INC);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) pc_q <= PC_RESET;
    else      pc_q <= pc_d;
  end

  assign imem_addr = pc_q;
  assign load_id   = branch_taken | enable__IF_ID;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      PC__IF_ID    <= '0;
      valid__IF_ID <= 1'b0;
    end else if (load_id) begin
      PC__IF_ID    <= pc_q;
      valid__IF_ID <= ~branch_taken;
    end
  end

  if_id_hold_buffer #(
    .WIDTH(XLEN)
  ) u_hold (
    .clk        (clk),
    .arst       (arst),
    .load_id    (load_id),
    .imem_rdata (imem_rdata),
    .instruction(instruction__IF_ID)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a synchronous memory model.
// A second instance with PC_RESET near the top of the address space covers wrap.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        arst, arst2;
  logic        pc_write, enable__IF_ID, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_rdata, pc_id, instr_id;
  logic        valid_id;
  logic [31:0] imem_addr2, imem_rdata2, pc_id2, instr_id2;
  logic        valid_id2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    imem_rdata  <= mem_f(imem_addr);
    imem_rdata2 <= mem_f(imem_addr2);
  end

  instruction_fetch_stage dut (
    .clk(clk), .arst(arst), .pc_write(pc_write), .enable__IF_ID(enable__IF_ID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PC__IF_ID(pc_id), .instruction__IF_ID(instr_id), .valid__IF_ID(valid_id)
  );

  instruction_fetch_stage #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .arst(arst2), .pc_write(pc_write), .enable__IF_ID(enable__IF_ID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .PC__IF_ID(pc_id2), .instruction__IF_ID(instr_id2), .valid__IF_ID(valid_id2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; arst2 = 1'b1;
    pc_write = 1'b1; enable__IF_ID = 1'b1; branch_taken = 1'b0; branch_target = '0;
    #2;
    n_checks++; if (pc_id !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc_id); end
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_id); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    #10 arst = 1'b0;
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e;
      e = 32'(4 * k);
      step();
      n_checks++; if (pc_id !== e) begin n_fail++; $display("FAIL run_pc[%0d] got %h exp %h", k, pc_id, e); end
      n_checks++; if (instr_id !== mem_f(e)) begin n_fail++; $display("FAIL run_instr[%0d] got %h exp %h", k, instr_id, mem_f(e)); end
      n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL run_valid[%0d] got %b exp 1", k, valid_id); end
    end
  endtask

  task automatic test_stall_one();
    pc_write = 1'b0; enable__IF_ID = 1'b0;
    step();
    n_checks++; if (pc_id !== 32'h8) begin n_fail++; $display("FAIL stall1_pc got %h exp 8", pc_id); end
    n_checks++; if (instr_id !== mem_f(32'h8)) begin n_fail++; $display("FAIL stall1_instr got %h exp %h", instr_id, mem_f(32'h8)); end
    n_checks++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall1_addr got %h exp c", imem_addr); end
    pc_write = 1'b1; enable__IF_ID = 1'b1;
    step();
    n_checks++; if (pc_id !== 32'hC) begin n_fail++; $display("FAIL stall1_next_pc got %h exp c", pc_id); end
    n_checks++; if (instr_id !== mem_f(32'hC)) begin n_fail++; $display("FAIL stall1_next_instr got %h exp %h", instr_id, mem_f(32'hC)); end
  endtask

  task automatic test_stall_three();
    step();
    n_checks++; if (pc_id !== 32'h10) begin n_fail++; $display("FAIL stall3_pre_pc got %h exp 10", pc_id); end
    pc_write = 1'b0; enable__IF_ID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (pc_id !== 32'h10) begin n_fail++; $display("FAIL stall3_pc[%0d] got %h exp 10", k, pc_id); end
      n_checks++; if (instr_id !== mem_f(32'h10)) begin n_fail++; $display("FAIL stall3_instr[%0d] got %h exp %h", k, instr_id, mem_f(32'h10)); end
      n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL stall3_valid[%0d] got %b exp 1", k, valid_id); end
    end
    pc_write = 1'b1; enable__IF_ID = 1'b1;
    step();
    n_checks++; if (pc_id !== 32'h14) begin n_fail++; $display("FAIL stall3_next_pc got %h exp 14", pc_id); end
    n_checks++; if (instr_id !== mem_f(32'h14)) begin n_fail++; $display("FAIL stall3_next_instr got %h exp %h", instr_id, mem_f(32'h14)); end
  endtask

  task automatic test_branch();
    step(); step();
    n_checks++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL br_pre_addr got %h exp 20", imem_addr); end
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL br_bubble_valid got %b exp 0", valid_id); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_addr got %h exp 100", imem_addr); end
    step();
    n_checks++; if (pc_id !== 32'h100) begin n_fail++; $display("FAIL br_pc got %h exp 100", pc_id); end
    n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL br_valid got %b exp 1", valid_id); end
    n_checks++; if (instr_id !== mem_f(32'h100)) begin n_fail++; $display("FAIL br_instr got %h exp %h", instr_id, mem_f(32'h100)); end
  endtask

  task automatic test_branch_in_stall();
    pc_write = 1'b0; enable__IF_ID = 1'b0;
    step();
    n_checks++; if (instr_id !== mem_f(32'h100)) begin n_fail++; $display("FAIL brst_hold_instr got %h exp %h", instr_id, mem_f(32'h100)); end
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL brst_bubble_valid got %b exp 0", valid_id); end
    n_checks++; if (pc_id !== 32'h104) begin n_fail++; $display("FAIL brst_bubble_pc got %h exp 104", pc_id); end
    n_checks++; if (instr_id !== mem_f(32'h104)) begin n_fail++; $display("FAIL brst_hold_clear got %h exp %h", instr_id, mem_f(32'h104)); end
    n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL brst_addr got %h exp 200", imem_addr); end
    pc_write = 1'b1; enable__IF_ID = 1'b1;
    step();
    n_checks++; if (pc_id !== 32'h200) begin n_fail++; $display("FAIL brst_pc got %h exp 200", pc_id); end
    n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL brst_valid got %b exp 1", valid_id); end
    n_checks++; if (instr_id !== mem_f(32'h200)) begin n_fail++; $display("FAIL brst_instr got %h exp %h", instr_id, mem_f(32'h200)); end
  endtask

  task automatic test_independent_controls();
    pc_write = 1'b0; enable__IF_ID = 1'b1;
    step();
    n_checks++; if (pc_id !== 32'h204) begin n_fail++; $display("FAIL indep_pc0 got %h exp 204", pc_id); end
    n_checks++; if (imem_addr !== 32'h204) begin n_fail++; $display("FAIL indep_addr got %h exp 204", imem_addr); end
    step();
    n_checks++; if (pc_id !== 32'h204) begin n_fail++; $display("FAIL indep_pc1 got %h exp 204", pc_id); end
    n_checks++; if (instr_id !== mem_f(32'h204)) begin n_fail++; $display("FAIL indep_instr got %h exp %h", instr_id, mem_f(32'h204)); end
    pc_write = 1'b1;
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
    pc_write = 1'b1; enable__IF_ID = 1'b1; branch_taken = 1'b0;
    arst2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (pc_id2 !== exp_pc[k]) begin n_fail++; $display("FAIL wrap_pc[%0d] got %h exp %h", k, pc_id2, exp_pc[k]); end
      n_checks++; if (instr_id2 !== mem_f(exp_pc[k])) begin n_fail++; $display("FAIL wrap_instr[%0d] got %h exp %h", k, instr_id2, mem_f(exp_pc[k])); end
      n_checks++; if (valid_id2 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d] got %b exp 1", k, valid_id2); end
    end
    pc_write = 1'b0; enable__IF_ID = 1'b0;
    step();
    n_checks++; if (instr_id2 !== mem_f(32'h4)) begin n_fail++; $display("FAIL wrap_hold got %h exp %h", instr_id2, mem_f(32'h4)); end
    #3 arst2 = 1'b1;
    #1;
    n_checks++; if (pc_id2 !== 32'h0) begin n_fail++; $display("FAIL arst_pc got %h exp 0", pc_id2); end
    n_checks++; if (valid_id2 !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b exp 0", valid_id2); end
    n_checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL arst_addr got %h exp fffffff8", imem_addr2); end
    n_checks++; if (instr_id2 !== mem_f(32'h8)) begin n_fail++; $display("FAIL arst_hold_clear got %h exp %h", instr_id2, mem_f(32'h8)); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall_one();
    test_stall_three();
    test_branch();
    test_branch_in_stall();
    test_independent_controls();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
